// File: rtl/fetch_predict_stage.sv
// Fetch stage with a 2-bit-counter branch history table and the IF/ID pipeline register.
// Only conditional branches are predicted; jumps and mispredicts are fixed by the EX redirect.
module fetch_predict_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          BHT_BITS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] inst_address,
  input  logic [31:0] instruction,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_instr,
  output logic        ifid_valid,
  output logic        ifid_pred_taken
);
  localparam int          ENTRIES   = 1 << BHT_BITS;
  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;

  logic [31:0]               pc, next_pc, b_imm, target;
  logic [ENTRIES-1:0][1:0]   bht;
  logic [BHT_BITS-1:0]       rd_idx, wr_idx;
  logic                      is_branch, pred_taken;

  assign inst_address = pc;
  assign rd_idx       = pc[BHT_BITS+1:2];
  assign wr_idx       = upd_pc[BHT_BITS+1:2];
  assign is_branch    = instruction[6:0] == OP_BRANCH;
  assign b_imm        = {{19{instruction[31]}}, instruction[31], instruction[7],
                         instruction[30:25], instruction[11:8], 1'b0};
  assign target       = pc + b_imm;
  // Lookup reads the registered table, so a same-cycle update is seen only by later fetches.
  assign pred_taken   = is_branch & bht[rd_idx][1];

  always_comb begin
    next_pc = pc + 32'd4;
    if (redirect_valid)  next_pc = {redirect_pc[31:2], 2'b00};
    else if (stall)      next_pc = pc;
    else if (pred_taken) next_pc = target;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= RESET_PC;
    else        pc <= next_pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_pc         <= '0;
      ifid_instr      <= NOP;
      ifid_valid      <= 1'b0;
      ifid_pred_taken <= 1'b0;
    end else if (redirect_valid) begin
      ifid_pc         <= '0;
      ifid_instr      <= NOP;
      ifid_valid      <= 1'b0;
      ifid_pred_taken <= 1'b0;
    end else if (!stall) begin
      ifid_pc         <= pc;
      ifid_instr      <= instruction;
      ifid_valid      <= 1'b1;
      ifid_pred_taken <= pred_taken;
    end
  end

  // Training comes from EX and is independent of fetch stalls and flushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) bht[i] <= 2'b01;
    end else if (upd_valid) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (wr_idx == BHT_BITS'(i)) begin
          if (upd_taken && bht[i] != 2'b11)       bht[i] <= bht[i] + 2'd1;
          else if (!upd_taken && bht[i] != 2'b00) bht[i] <= bht[i] - 2'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_fetch_predict_stage.sv
// Directed bench: each stimulus cycle pushes the hand-computed post-edge state into a
// scoreboard queue; an independent monitor pops and compares after every rising edge.
module tb_fetch_predict_stage;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] BEQ8  = 32'h0000_0463;  // beq x0,x0,+8
  localparam logic [31:0] BBACK = 32'hFE00_08E3;  // beq x0,x0,-16
  localparam logic [31:0] JAL   = 32'h0080_006F;  // jal x0,+8

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst_address, instruction, redirect_pc, upd_pc;
  logic        stall, redirect_valid, upd_valid, upd_taken;
  logic [31:0] ifid_pc, ifid_instr;
  logic        ifid_valid, ifid_pred_taken;

  fetch_predict_stage dut (
    .clk(clk), .rst_n(rst_n), .inst_address(inst_address), .instruction(instruction),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .ifid_pc(ifid_pc), .ifid_instr(ifid_instr), .ifid_valid(ifid_valid),
    .ifid_pred_taken(ifid_pred_taken)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [31:0] addr, pc, instr;
    logic        vld, pred;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string nm, input string f, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s actual=%h expected=%h", nm, f, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk(e.nm, "inst_address", inst_address, e.addr);
        chk(e.nm, "ifid_pc", ifid_pc, e.pc);
        chk(e.nm, "ifid_instr", ifid_instr, e.instr);
        chk(e.nm, "ifid_valid", {31'd0, ifid_valid}, {31'd0, e.vld});
        chk(e.nm, "ifid_pred_taken", {31'd0, ifid_pred_taken}, {31'd0, e.pred});
      end
    end
  end

  task automatic push(input string nm, input logic [31:0] ea, ep, ei, input logic ev, epr);
    exp_t e;
    e.nm = nm; e.addr = ea; e.pc = ep; e.instr = ei; e.vld = ev; e.pred = epr;
    sb.push_back(e);
  endtask

  // One clock cycle: drive inputs, record expected state after the coming edge.
  task automatic step(input string nm, input logic [31:0] ins, input logic st, rv,
                      input logic [31:0] rpc, input logic uv, input logic [31:0] upc,
                      input logic ut, input logic [31:0] ea, ep, ei, input logic ev, epr);
    instruction = ins; stall = st; redirect_valid = rv; redirect_pc = rpc;
    upd_valid = uv; upd_pc = upc; upd_taken = ut;
    push(nm, ea, ep, ei, ev, epr);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] p;
    rst_n = 1'b0; instruction = NOP; stall = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
    push("reset", 32'h0, 32'h0, NOP, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    step("idle0", NOP, 0, 0, 0, 0, 0, 0, 32'h4, 32'h0, NOP, 1, 0);
    step("idle1", NOP, 0, 0, 0, 0, 0, 0, 32'h8, 32'h4, NOP, 1, 0);
    step("idle2", NOP, 0, 0, 0, 0, 0, 0, 32'hC, 32'h8, NOP, 1, 0);
    step("idle3", NOP, 0, 0, 0, 0, 0, 0, 32'h10, 32'hC, NOP, 1, 0);
    step("br_nt", BEQ8, 0, 0, 0, 0, 0, 0, 32'h14, 32'h10, BEQ8, 1, 0);
    step("upd1", NOP, 0, 0, 0, 1, 32'h10, 1, 32'h18, 32'h14, NOP, 1, 0);
    step("upd2", NOP, 0, 0, 0, 1, 32'h10, 1, 32'h1C, 32'h18, NOP, 1, 0);
    step("rd_10", NOP, 0, 1, 32'h10, 0, 0, 0, 32'h10, 32'h0, NOP, 0, 0);
    step("br_t", BEQ8, 0, 0, 0, 0, 0, 0, 32'h18, 32'h10, BEQ8, 1, 1);
    step("stall1", NOP, 1, 0, 0, 0, 0, 0, 32'h18, 32'h10, BEQ8, 1, 1);
    step("stall_rd", NOP, 1, 1, 32'h103, 0, 0, 0, 32'h100, 32'h0, NOP, 0, 0);

    // same-cycle lookup and update on index 3
    step("rd_c", NOP, 0, 1, 32'hC, 0, 0, 0, 32'hC, 32'h0, NOP, 0, 0);
    step("same_idx", BEQ8, 0, 0, 0, 1, 32'hC, 1, 32'h10, 32'hC, BEQ8, 1, 0);
    step("rd_c2", NOP, 0, 1, 32'hC, 0, 0, 0, 32'hC, 32'h0, NOP, 0, 0);
    step("after_upd", BEQ8, 0, 0, 0, 0, 0, 0, 32'h14, 32'hC, BEQ8, 1, 1);

    // saturate index 3 low: 10 -> 00, then one increment must give 01 (not taken)
    for (int k = 0; k < 5; k++) begin
      p = 32'h14 + 32'(4 * k);
      step("dec", NOP, 0, 0, 0, 1, 32'hC, 0, p + 32'h4, p, NOP, 1, 0);
    end
    step("inc1", NOP, 0, 0, 0, 1, 32'hC, 1, 32'h2C, 32'h28, NOP, 1, 0);
    step("rd_c3", NOP, 0, 1, 32'hC, 0, 0, 0, 32'hC, 32'h0, NOP, 0, 0);
    step("sat_low", BEQ8, 0, 0, 0, 0, 0, 0, 32'h10, 32'hC, BEQ8, 1, 0);

    // saturate high: 01 -> 11, then one decrement must give 10 (taken)
    for (int k = 0; k < 5; k++) begin
      p = 32'h10 + 32'(4 * k);
      step("inc", NOP, 0, 0, 0, 1, 32'hC, 1, p + 32'h4, p, NOP, 1, 0);
    end
    step("dec1", NOP, 0, 0, 0, 1, 32'hC, 0, 32'h28, 32'h24, NOP, 1, 0);
    step("rd_c4", NOP, 0, 1, 32'hC, 0, 0, 0, 32'hC, 32'h0, NOP, 0, 0);
    step("sat_high", BEQ8, 0, 0, 0, 0, 0, 0, 32'h14, 32'hC, BEQ8, 1, 1);

    // PC wrap and backward branch across zero
    step("rd_wrap", NOP, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 32'hFFFF_FFFC, 32'h0, NOP, 0, 0);
    step("wrap", NOP, 0, 0, 0, 0, 0, 0, 32'h0, 32'hFFFF_FFFC, NOP, 1, 0);
    step("upd8", NOP, 0, 0, 0, 1, 32'h8, 1, 32'h4, 32'h0, NOP, 1, 0);
    step("pc4", NOP, 0, 0, 0, 0, 0, 0, 32'h8, 32'h4, NOP, 1, 0);
    step("back", BBACK, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFF8, 32'h8, BBACK, 1, 1);

    // jal at a strongly-taken index is not predicted
    step("rd_jal", NOP, 0, 1, 32'h10, 0, 0, 0, 32'h10, 32'h0, NOP, 0, 0);
    step("jal", JAL, 0, 0, 0, 0, 0, 0, 32'h14, 32'h10, JAL, 1, 0);

    // async reset during stall+redirect wins; table returns to weakly not-taken
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
    #2 rst_n = 1'b0;
    push("reset2", 32'h0, 32'h0, NOP, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      p = 32'(4 * k);
      step("post_rst", NOP, 0, 0, 0, 0, 0, 0, p + 32'h4, p, NOP, 1, 0);
    end
    step("bht_reset", BEQ8, 0, 0, 0, 0, 0, 0, 32'h14, 32'h10, BEQ8, 1, 0);

    for (int k = 0; k < 10 && sb.size() > 0; k++) begin
      @(posedge clk);
      #3;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d expected=0 pending entries", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
